// File: rtl/mmio_fifo_ctrl.sv
// MMIO front end for an external show-ahead FIFO: push/pop data port, status,
// control and interrupt threshold registers, with single-cycle read responses.
module mmio_fifo_ctrl #(
  parameter int          DEPTH = 8,
  parameter int          BITS  = 64,
  parameter logic [15:0] BASE  = 16'h0020
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mmio_wr_valid,
  input  logic            mmio_rd_valid,
  input  logic [15:0]     mmio_addr,
  input  logic [8:0]      mmio_tid,
  input  logic [BITS-1:0] mmio_wdata,
  output logic            rsp_valid,
  output logic [8:0]      rsp_tid,
  output logic [BITS-1:0] rsp_data,
  output logic            fifo_push,
  output logic [BITS-1:0] fifo_din,
  output logic            fifo_pop,
  input  logic [BITS-1:0] fifo_dout,
  output logic            fifo_flush,
  output logic            irq_level
);

  localparam int             CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [1:0]     REG_DATA = 2'd0;
  localparam logic [1:0]     REG_STAT = 2'd1;
  localparam logic [1:0]     REG_CTRL = 2'd2;
  localparam logic [1:0]     REG_THR  = 2'd3;

  logic [CW-1:0]   count;
  logic [CW-1:0]   thresh;
  logic            enable;
  logic            ovf;
  logic            unf;
  logic            flush_q;

  logic [15:0]     offset;
  logic            hit;
  logic [1:0]      reg_sel;
  logic            push_req, pop_req, ctrl_wr, thr_wr;
  logic            is_empty, is_full;
  logic            pop_ok, push_ok, ovf_set, unf_set;
  logic            sticky_clr, flush_req;
  logic [BITS-1:0] rd_word;

  // Subtraction wraps for addresses below BASE, so a single range check suffices.
  assign offset  = mmio_addr - BASE;
  assign hit     = (offset < 16'd8) && !offset[0];
  assign reg_sel = offset[2:1];

  assign push_req = mmio_wr_valid && hit && (reg_sel == REG_DATA);
  assign pop_req  = mmio_rd_valid && hit && (reg_sel == REG_DATA);
  assign ctrl_wr  = mmio_wr_valid && hit && (reg_sel == REG_CTRL);
  assign thr_wr   = mmio_wr_valid && hit && (reg_sel == REG_THR);

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);

  // Storage is being cleared while flush_q is high, so data traffic is held off.
  assign pop_ok  = pop_req && !flush_q && !is_empty;
  assign push_ok = push_req && !flush_q && enable && (!is_full || pop_ok);
  assign ovf_set = push_req && !flush_q && enable && is_full && !pop_ok;
  assign unf_set = pop_req && !flush_q && is_empty;

  assign sticky_clr = ctrl_wr && mmio_wdata[0];
  assign flush_req  = ctrl_wr && mmio_wdata[1];

  assign fifo_push  = push_ok;
  assign fifo_din   = mmio_wdata;
  assign fifo_pop   = pop_ok;
  assign fifo_flush = flush_q;
  assign irq_level  = !is_empty && (count >= thresh);

  // Reads see register state from before this cycle's updates.
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_DATA: if (pop_ok) rd_word = fifo_dout;
      REG_STAT: begin
        rd_word[15:0] = 16'(count);
        rd_word[16]   = is_empty;
        rd_word[17]   = is_full;
        rd_word[18]   = ovf;
        rd_word[19]   = unf;
      end
      REG_CTRL: rd_word[2] = enable;
      REG_THR:  rd_word[CW-1:0] = thresh;
      default:  rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      thresh  <= '0;
      enable  <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      if (flush_req)
        count <= '0;
      else if (push_ok && !pop_ok)
        count <= count + CW'(1);
      else if (pop_ok && !push_ok)
        count <= count - CW'(1);

      // A fresh error in the same cycle as a clear keeps the flag set.
      ovf     <= (ovf && !sticky_clr) || ovf_set;
      unf     <= (unf && !sticky_clr) || unf_set;
      flush_q <= flush_req;
      if (ctrl_wr) enable <= mmio_wdata[2];
      if (thr_wr)  thresh <= mmio_wdata[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= mmio_rd_valid && hit;
      if (mmio_rd_valid && hit) begin
        rsp_tid  <= mmio_tid;
        rsp_data <= rd_word;
      end
    end
  end

endmodule
